// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory arbiter (contention policy macro: DMEM_ARB_RR_EN)
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_LAST = 2'd1,
    ACC_LOCK = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_ACC  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational winner select; DMEM_ARB_RR_EN selects round-robin contention
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int BURST_MAX = 8,
  parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic             cpu_req,
  input  logic             acc_req,
  input  arb_state_t       state,
  input  logic [CNT_W-1:0] burst_cnt,
  output owner_t           owner
);

  logic cap_hit;

  assign cap_hit = (burst_cnt == CNT_W'(BURST_MAX));

  always_comb begin
    owner = OWN_NONE;
    if (state == ACC_LOCK && acc_req) begin
      // A waiting CPU breaks the lock once the burst cap is reached.
      if (cpu_req && cap_hit) owner = OWN_CPU;
      else                    owner = OWN_ACC;
    end else if (cpu_req && acc_req) begin
`ifdef DMEM_ARB_RR_EN
      if (state == CPU_LAST) owner = OWN_ACC;
      else                   owner = OWN_CPU;
`else
      owner = OWN_CPU;
`endif
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end else if (acc_req) begin
      owner = OWN_ACC;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares data_mem between CPU MEM stage and accelerator; DMEM_ARB_RR_EN enables round-robin
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic [WIDTH-1:0]  cpu_rdata,
  output logic              cpu_stall,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic              acc_lock,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [WIDTH-1:0]  acc_wdata,
  output logic              acc_gnt,
  output logic [WIDTH-1:0]  acc_rdata,
  output logic              acc_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  owner_t           owner_raw, owner;
  logic             cpu_gnt;

  dmem_arb_pick #(.BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) u_pick (
    .cpu_req   (cpu_req),
    .acc_req   (acc_req),
    .state     (state),
    .burst_cnt (burst_cnt),
    .owner     (owner_raw)
  );

  // Nothing is granted while reset is held, so memory sees no write.
  always_comb begin
    owner = OWN_NONE;
    if (rst) owner = owner_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = '0;
    case (owner)
      OWN_ACC: begin
        if (acc_lock) begin
          state_nxt = ACC_LOCK;
          cnt_nxt   = cpu_req ? burst_cnt + 1'b1 : burst_cnt;
        end
      end
      OWN_CPU: state_nxt = CPU_LAST;
      default: ;
    endcase
  end

  always_comb begin
    acc_gnt   = (owner == OWN_ACC);
    cpu_gnt   = (owner == OWN_CPU);
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (acc_gnt) begin
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
      mem_we    = acc_we;
    end else if (cpu_gnt) begin
      mem_we = cpu_we;
    end
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_rvalid <= 1'b0;
      acc_rdata  <= '0;
    end else begin
      acc_rvalid <= acc_gnt & ~acc_we;
      if (acc_gnt && !acc_we) acc_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven bench with read-data scoreboard; honours DMEM_ARB_RR_EN
module tb_dmem_arbiter;

  localparam int WIDTH     = 32;
  localparam int ADDR_W    = 32;
  localparam int BURST_MAX = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, acc_req, acc_we, acc_lock;
  logic [ADDR_W-1:0] cpu_addr, acc_addr, mem_addr;
  logic [WIDTH-1:0]  cpu_wdata, acc_wdata, cpu_rdata, acc_rdata, mem_wdata, mem_rdata;
  logic              cpu_stall, acc_gnt, acc_rvalid, mem_we;
  logic              fill;

  logic [31:0] data_mem [256];
  logic [31:0] ref_mem  [256];
  logic [31:0] sb [$];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        areq, awe, alock;
    logic [31:0] aaddr, awd;
    logic        xs, xg, xw;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .acc_req(acc_req), .acc_we(acc_we), .acc_lock(acc_lock), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = data_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) data_mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (mem_we) begin
      data_mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  function automatic vec_t mk(input logic creq, cwe, input logic [31:0] caddr, cwd,
                              input logic areq, awe, alock, input logic [31:0] aaddr, awd,
                              input logic xs, xg, xw);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.areq = areq; v.awe = awe; v.alock = alock; v.aaddr = aaddr; v.awd = awd;
    v.xs = xs; v.xg = xg; v.xw = xw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    acc_req = v.areq; acc_we = v.awe; acc_lock = v.alock; acc_addr = v.aaddr; acc_wdata = v.awd;
  endtask

  task automatic check_comb(input vec_t v, input string tag);
    logic [31:0] xa, xd;
    xa = v.xg ? v.aaddr : v.caddr;
    xd = v.xg ? v.awd : v.cwd;
    #1;
    chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'(v.xs));
    chk({tag, " acc_gnt"}, 32'(acc_gnt), 32'(v.xg));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(v.xw));
    chk({tag, " mem_addr"}, mem_addr, xa);
    if (v.xw) chk({tag, " mem_wdata"}, mem_wdata, xd);
    if (v.creq && !v.xs && !v.cwe) chk({tag, " cpu_rdata"}, cpu_rdata, ref_mem[v.caddr[9:2]]);
    if (v.xg && !v.awe) sb.push_back(ref_mem[v.aaddr[9:2]]);
    if (v.xw) ref_mem[xa[9:2]] = xd;
  endtask

  task automatic check_seq(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    chk({tag, " acc_rvalid"}, 32'(acc_rvalid), 32'(v.xg && !v.awe));
    if (acc_rvalid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL %s acc_rdata: got %h, want no read pending", tag, acc_rdata);
      end else begin
        chk({tag, " acc_rdata"}, acc_rdata, sb.pop_front());
      end
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    apply(v);
    check_comb(v, tag);
    check_seq(v, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rr;
`ifdef DMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);

    // Reset holds every grant off even with both masters requesting.
    fill = 1'b1; rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h180; cpu_wdata = 32'h1111_1111;
    acc_req = 1'b1; acc_we = 1'b1; acc_lock = 1'b1; acc_addr = 32'h184; acc_wdata = 32'h2222_2222;
    @(posedge clk);
    #1;
    fill = 1'b0;
    chk("reset acc_gnt", 32'(acc_gnt), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset cpu_stall", 32'(cpu_stall), 32'd1);
    chk("reset acc_rvalid", 32'(acc_rvalid), 32'd0);
    chk("reset acc_rdata", acc_rdata, 32'd0);
    chk("reset mem_addr", mem_addr, 32'h180);
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b0; acc_req = 1'b0; cpu_we = 1'b0; acc_we = 1'b0; acc_lock = 1'b0;

    tbl.push_back(mk(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 32'h100, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 32'h0, 32'h0, 1, 0, (k < 3), 32'h100 + 32'(4 * k), 32'h0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 32'h104, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h108, 32'h0, 1, 0, 0, 32'h10C, 32'h0, rr, rr, 0));
    tbl.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h110, 32'h0, 1, 1, 0, 32'h114, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Locked burst against a waiting CPU: exactly BURST_MAX stalls, then CPU, then acc again.
    step(mk(0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h120, 32'h0, 0, 1, 0), "burst start");
    for (int k = 0; k < BURST_MAX; k++)
      step(mk(1, 0, 32'h140, 32'h0, 1, 0, 1, 32'h124 + 32'(4 * k), 32'h0, 1, 1, 0),
           $sformatf("burst beat%0d", k));
    step(mk(1, 0, 32'h140, 32'h0, 1, 0, 1, 32'h144, 32'h0, 0, 0, 0), "burst cpu cap");
    step(mk(0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h144, 32'h0, 0, 1, 0), "burst resume");

    // Reset mid-burst after three beats.
    for (int k = 0; k < 3; k++)
      step(mk(0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h100 + 32'(4 * k), 32'h0, 0, 1, 0),
           $sformatf("rburst beat%0d", k));
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h148;
    acc_req = 1'b1; acc_we = 1'b1; acc_lock = 1'b1; acc_addr = 32'h10C; acc_wdata = 32'hBAD0BAD0;
    rst = 1'b0;
    #1;
    chk("midreset acc_gnt", 32'(acc_gnt), 32'd0);
    chk("midreset acc_rvalid", 32'(acc_rvalid), 32'd0);
    chk("midreset mem_we", 32'(mem_we), 32'd0);
    chk("midreset cpu_stall", 32'(cpu_stall), 32'd1);
    chk("midreset acc_rdata", acc_rdata, 32'd0);
    @(posedge clk);
    #1;
    chk("midreset held rvalid", 32'(acc_rvalid), 32'd0);
    rst = 1'b1;
    step(mk(1, 0, 32'h148, 32'h0, 1, 0, 1, 32'h10C, 32'h0, 0, 0, 0), "post-reset idle");
    step(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0), "post-reset quiet");

    chk("denied acc write mem[0x114]", data_mem[8'h45], 32'hC0DE_0045);
    chk("reset acc write mem[0x10C]", data_mem[8'h43], 32'hC0DE_0043);
    chk("cpu store mem[0x100]", data_mem[8'h40], 32'hDEADBEEF);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
